// File: rtl/tm_pkg.sv
// rtl/tm_pkg.sv - shared types, defaults and width helpers for the TM inference sequencer
package tm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam int DEF_CHUNK_W     = 64;
  localparam int DEF_NUM_CHUNKS  = 4;
  localparam int DEF_NUM_CLAUSES = 10;

  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Tally counts 0..NUM_CLAUSES/2 inclusive
  function automatic int tally_w(input int clauses);
    return $clog2(clauses / 2 + 1);
  endfunction

endpackage

// File: rtl/tm_chunk_eval.sv
// rtl/tm_chunk_eval.sv - combinational clause evaluation of one feature slice
module tm_chunk_eval #(
  parameter int W = 64
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] ep,
  input  logic [W-1:0] en,
  output logic         fail,
  output logic         incl
);

  // An included literal that evaluates false kills the conjunction
  assign fail = |((~ep & ~x) | (~en & x));
  assign incl = ~&{en, ep};

endmodule

// File: rtl/tm_inference_sequencer.sv
// rtl/tm_inference_sequencer.sv - time-multiplexed Tsetlin Machine clause evaluation and voting
module tm_inference_sequencer
  import tm_pkg::*;
#(
  parameter int CHUNK_W     = DEF_CHUNK_W,
  parameter int NUM_CHUNKS  = DEF_NUM_CHUNKS,
  parameter int NUM_CLAUSES = DEF_NUM_CLAUSES
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         start,
  output logic                                         busy,
  output logic                                         rd_en,
  output logic [addr_w(NUM_CHUNKS)-1:0]                feat_addr,
  output logic [addr_w(NUM_CLAUSES*NUM_CHUNKS)-1:0]    excl_addr,
  input  logic [CHUNK_W-1:0]                           feat_rdata,
  input  logic [2*CHUNK_W-1:0]                         excl_rdata,
  output logic                                         done,
  output logic                                         verdict,
  output logic [tally_w(NUM_CLAUSES)-1:0]              pos_count,
  output logic [tally_w(NUM_CLAUSES)-1:0]              neg_count
);

  localparam int FA_W = addr_w(NUM_CHUNKS);
  localparam int EA_W = addr_w(NUM_CLAUSES * NUM_CHUNKS);
  localparam int CL_W = addr_w(NUM_CLAUSES);
  localparam int T_W  = tally_w(NUM_CLAUSES);

  state_t            state, state_nxt;
  logic [FA_W-1:0]   chunk;
  logic [CL_W-1:0]   clause;
  logic [EA_W-1:0]   lin;
  logic              last_chunk, last_read;

  logic              p_valid, p_first, p_last, p_pos;
  logic              fail, incl;
  logic              clause_ok, any_incl;
  logic              ok_in, inc_in, clause_out;
  logic              pos_inc, neg_inc;
  logic [T_W-1:0]    pos_tally, neg_tally, pos_nxt, neg_nxt;

  assign last_chunk = (chunk == FA_W'(NUM_CHUNKS - 1));
  assign last_read  = (state == RUN) && last_chunk && (clause == CL_W'(NUM_CLAUSES - 1));
  assign feat_addr  = chunk;
  assign excl_addr  = lin;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    rd_en     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        rd_en = 1'b1;
        if (last_read) state_nxt = DRAIN;
      end
      DRAIN: state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // lin tracks clause*NUM_CHUNKS+chunk so no multiplier is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk  <= '0;
      clause <= '0;
      lin    <= '0;
    end else if (state == RUN) begin
      if (last_chunk) begin
        chunk  <= '0;
        clause <= last_read ? '0 : clause + CL_W'(1);
      end else begin
        chunk  <= chunk + FA_W'(1);
      end
      lin <= last_read ? '0 : lin + EA_W'(1);
    end
  end

  // Slice attributes delayed to line up with the RAM read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_valid <= 1'b0;
      p_first <= 1'b0;
      p_last  <= 1'b0;
      p_pos   <= 1'b0;
    end else begin
      p_valid <= rd_en;
      p_first <= (chunk == '0);
      p_last  <= last_chunk;
      p_pos   <= (clause >= CL_W'(NUM_CLAUSES / 2));
    end
  end

  tm_chunk_eval #(.W(CHUNK_W)) u_eval (
    .x    (feat_rdata),
    .ep   (excl_rdata[CHUNK_W-1:0]),
    .en   (excl_rdata[2*CHUNK_W-1:CHUNK_W]),
    .fail (fail),
    .incl (incl)
  );

  assign ok_in      = p_first ? 1'b1 : clause_ok;
  assign inc_in     = p_first ? 1'b0 : any_incl;
  assign clause_out = ok_in & ~fail & (inc_in | incl);
  assign pos_inc    = p_valid & p_last & p_pos & clause_out;
  assign neg_inc    = p_valid & p_last & ~p_pos & clause_out;
  assign pos_nxt    = pos_tally + T_W'(pos_inc);
  assign neg_nxt    = neg_tally + T_W'(neg_inc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clause_ok <= 1'b0;
      any_incl  <= 1'b0;
      pos_tally <= '0;
      neg_tally <= '0;
    end else begin
      if (p_valid) begin
        clause_ok <= ok_in & ~fail;
        any_incl  <= inc_in | incl;
      end
      if (state == IDLE && start) begin
        pos_tally <= '0;
        neg_tally <= '0;
      end else if (p_valid) begin
        pos_tally <= pos_nxt;
        neg_tally <= neg_nxt;
      end
    end
  end

  // Loaded from the final tally so results are visible alongside done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_count <= '0;
      neg_count <= '0;
      verdict   <= 1'b0;
    end else if (state == DRAIN) begin
      pos_count <= pos_nxt;
      neg_count <= neg_nxt;
      verdict   <= (pos_nxt > neg_nxt);
    end
  end

endmodule

// File: tb/tb_tm_inference_sequencer.sv
// tb/tb_tm_inference_sequencer.sv - self-checking bench for tm_inference_sequencer
module tb_tm_inference_sequencer;

  localparam int CW  = 64;
  localparam int NC  = 4;
  localparam int NCL = 10;
  localparam int N   = NCL * NC;

  logic         clk = 1'b0;
  logic         rst_n, start, busy, rd_en, done, verdict;
  logic [1:0]   feat_addr;
  logic [5:0]   excl_addr;
  logic [63:0]  feat_rdata = '0;
  logic [127:0] excl_rdata = '0;
  logic [2:0]   pos_count, neg_count;

  logic [63:0]  feat_mem [NC];
  logic [127:0] excl_mem [N];

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string name;
    int    kind;
    bit    fv;
    int    pos;
    int    neg;
    bit    verd;
  } vec_t;
  vec_t tbl [6];

  tm_inference_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .rd_en      (rd_en),
    .feat_addr  (feat_addr),
    .excl_addr  (excl_addr),
    .feat_rdata (feat_rdata),
    .excl_rdata (excl_rdata),
    .done       (done),
    .verdict    (verdict),
    .pos_count  (pos_count),
    .neg_count  (neg_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_en) begin
      feat_rdata <= feat_mem[feat_addr];
      excl_rdata <= excl_mem[excl_addr];
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < NC; i++) feat_mem[i] = '0;
    for (int i = 0; i < N; i++)  excl_mem[i] = '1;
  endtask

  task automatic set_feat(input int f, input bit v);
    feat_mem[f / CW][f % CW] = v;
  endtask

  task automatic incl_lit(input int c, input int f, input bit neg);
    excl_mem[c * NC + f / CW][(neg ? CW : 0) + f % CW] = 1'b0;
  endtask

  // Reference: a clause fires when it includes at least one literal and every included literal is true
  task automatic model(output int p, output int n);
    p = 0;
    n = 0;
    for (int c = 0; c < NCL; c++) begin
      bit any, ok, x;
      logic [127:0] w;
      any = 0;
      ok  = 1;
      for (int f = 0; f < CW * NC; f++) begin
        w = excl_mem[c * NC + f / CW];
        x = feat_mem[f / CW][f % CW];
        if (!w[f % CW])      begin any = 1; if (!x) ok = 0; end
        if (!w[CW + f % CW]) begin any = 1; if (x)  ok = 0; end
      end
      if (any && ok) begin
        if (c >= NCL / 2) p++;
        else              n++;
      end
    end
  endtask

  task automatic setup(input int kind, input bit fv);
    clear_mem();
    case (kind)
      0: for (int i = 0; i < NC; i++) feat_mem[i] = {$urandom, $urandom};
      1: begin incl_lit(7, 3, 0); set_feat(3, fv); end
      2: begin
        for (int c = 0; c < NCL / 2; c++)   incl_lit(c, 130, 0);
        for (int c = NCL / 2; c < NCL; c++) incl_lit(c, 130, 1);
        set_feat(130, fv);
      end
      default: begin incl_lit(5, 0, 0); incl_lit(0, 0, 0); set_feat(0, 1'b1); end
    endcase
  endtask

  // mode 0 plain, 1 extra start at cycle 10, 2 reset at cycle 20, 3 start held high
  task automatic run(input int mode, output int done_at, output int done_n,
                     output int rd_n, output int seq_err);
    int lim;
    done_at = -1;
    done_n  = 0;
    rd_n    = 0;
    seq_err = 0;
    lim     = (mode == 3) ? 100 : 60;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= lim; k++) begin
      @(negedge clk);
      if (rd_en) begin
        if (excl_addr != rd_n % N || feat_addr != rd_n % NC) seq_err++;
        rd_n++;
      end
      if (mode <= 1 && (rd_en != (k <= N) || busy != (k <= N + 2))) seq_err++;
      if (mode == 3 && (k == 43 || k == 44) && rd_en != (k == 44)) seq_err++;
      if (mode == 2 && k > 20 && rd_en) seq_err++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = k;
      end
      if (mode == 1)                 start = (k == 10);
      else if (mode != 3 && k == 1)  start = 1'b0;
      if (mode == 3 && k == 44)      start = 1'b0;
      if (mode == 2 && k == 20) begin
        rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_excl_addr", excl_addr, 0);
        check("rst_pos", pos_count, 0);
        check("rst_neg", neg_count, 0);
        check("rst_verdict", verdict, 0);
      end
      if (mode == 2 && k == 22) rst_n = 1'b1;
    end
  endtask

  initial begin
    int da, dn, rn, se, mp, mn;
    rst_n = 1'b0;
    start = 1'b0;
    clear_mem();
    tbl[0] = '{"all_excl", 0, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{"c7_x3_hi", 1, 1'b1, 1, 0, 1'b1};
    tbl[2] = '{"c7_x3_lo", 1, 1'b0, 0, 0, 1'b0};
    tbl[3] = '{"split_f1", 2, 1'b1, 0, 5, 1'b0};
    tbl[4] = '{"split_f0", 2, 1'b0, 5, 0, 1'b1};
    tbl[5] = '{"tie",      3, 1'b1, 1, 1, 1'b0};

    repeat (2) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_rd_en", rd_en, 0);
    check("reset_done", done, 0);
    check("reset_counts", {verdict, pos_count, neg_count}, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_no_rd_en", rd_en, 0);

    for (int i = 0; i < 6; i++) begin
      setup(tbl[i].kind, tbl[i].fv);
      run(0, da, dn, rn, se);
      check({tbl[i].name, "_done_at"}, da, N + 2);
      check({tbl[i].name, "_done_n"}, dn, 1);
      check({tbl[i].name, "_rd_n"}, rn, N);
      check({tbl[i].name, "_seq"}, se, 0);
      check({tbl[i].name, "_pos"}, pos_count, tbl[i].pos);
      check({tbl[i].name, "_neg"}, neg_count, tbl[i].neg);
      check({tbl[i].name, "_verdict"}, verdict, tbl[i].verd);
    end

    for (int t = 0; t < 15; t++) begin
      clear_mem();
      for (int i = 0; i < NC; i++) feat_mem[i] = {$urandom, $urandom};
      for (int c = 0; c < NCL; c++) begin
        int nl;
        nl = $urandom_range(0, 3);
        for (int j = 0; j < nl; j++) begin
          int f;
          bit want;
          f    = $urandom_range(0, CW * NC - 1);
          want = ($urandom_range(0, 3) != 0);
          incl_lit(c, f, want ? ~feat_mem[f / CW][f % CW] : feat_mem[f / CW][f % CW]);
        end
      end
      model(mp, mn);
      run(0, da, dn, rn, se);
      check("rand_done_at", da, N + 2);
      check("rand_pos", pos_count, mp);
      check("rand_neg", neg_count, mn);
      check("rand_verdict", verdict, int'(mp > mn));
    end

    setup(3, 1'b1);
    run(1, da, dn, rn, se);
    check("restart_ignored_done_at", da, N + 2);
    check("restart_ignored_done_n", dn, 1);
    check("restart_ignored_rd_n", rn, N);
    check("restart_ignored_seq", se, 0);

    run(3, da, dn, rn, se);
    check("held_start_done_n", dn, 2);
    check("held_start_rd_n", rn, 2 * N);
    check("held_start_seq", se, 0);
    check("held_start_pos", pos_count, 1);

    setup(2, 1'b0);
    run(0, da, dn, rn, se);
    check("pre_abort_pos", pos_count, 5);
    run(2, da, dn, rn, se);
    check("abort_done_n", dn, 0);
    check("abort_seq", se, 0);
    check("abort_pos_held", pos_count, 0);
    check("abort_verdict_held", verdict, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
